spi_shift_engine: RTL
=====================

Name: spi_shift_engine

Overview:
Parametrised SPI data-path shifter running on a single system clock, with single-cycle Sample_en/Shift_en strobes from the SPI clock generator in place of separate sample and shift clocks. Separate TX and RX shift registers, selectable MSB/LSB-first order, CPHA-aware first-bit launch, a buffered receive register with full/overrun flags, and write-collision detection. A write to SPDR starts a transfer. Sits between the SPI register file/controller and the MOSI/MISO pins in both master and slave builds.

Parameters:
DWIDTH, 8, transfer and SPDR width in bits (legal range 2 to 32)
CNT_W, $clog2(DWIDTH+1), bit-counter width (derived; do not override)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous active-high reset
Sample_en  in  1  one-cycle strobe: capture Data_in
Shift_en  in  1  one-cycle strobe: advance Data_out
Data_in  in  1  serial input (MISO in master, MOSI in slave)
Cpha  in  1  0: first bit driven at load; 1: first bit driven on first Shift_en
Lsb_first  in  1  1: LSB transmitted/received first
Abort  in  1  synchronous transfer cancel
SPDR_wr_en  in  1  write SPDR_in, starts transfer when idle
SPDR_in  in  DWIDTH  transmit data
SPDR_rd_en  in  1  read receive buffer
SPDR_out  out  DWIDTH  receive buffer when SPDR_rd_en=1, else 0 (no tri-state)
Data_out  out  1  serial output
Busy  out  1  transfer in progress
Done  out  1  one-cycle pulse at transfer completion
Rx_full  out  1  unread data in receive buffer
Ovr  out  1  sticky overrun
Wcol  out  1  sticky write collision

Behaviour:
- Reset (async): state IDLE, tx_reg/rx_reg/rx_buf/bit_cnt = 0, Data_out/Busy/Done/Rx_full/Ovr/Wcol = 0. A reset mid-transfer discards the transfer with no Done.
- States: IDLE, XFER. IDLE→XFER on SPDR_wr_en. XFER→IDLE when bit_cnt reaches DWIDTH, or on Abort.
- Load (IDLE, SPDR_wr_en): tx_reg<=SPDR_in, bit_cnt<=0, Busy<=1 next cycle. If Cpha=0, Data_out<=first bit (SPDR_in[DWIDTH-1], or SPDR_in[0] if Lsb_first) in the same edge. If Cpha=1, Data_out holds its value.
- Shift_en in XFER: Cpha=0 drives the next bit. Cpha=1 drives the current head bit on the first strobe and the next bit thereafter. Shift_en is ignored in IDLE.
- Sample_en in XFER: Data_in shifts into rx_reg (into the LSB side if MSB-first, into the MSB side if Lsb_first), and bit_cnt increments.
- Completion: on the Sample_en that makes bit_cnt=DWIDTH:
  - rx_buf<=assembled word including that bit.
  - Done=1 for one cycle; Busy<=0; go to IDLE.
  - Set Ovr if Rx_full was already 1. The new data overwrites rx_buf. Rx_full<=1.
- Sample_en and Shift_en in the same cycle: both actions execute independently.
- SPDR_wr_en while Busy: data ignored, transfer undisturbed, Wcol<=1.
- SPDR_rd_en: SPDR_out is combinational (zero latency). The next edge clears Rx_full, Ovr and Wcol.
- Read in the same cycle as completion: SPDR_out returns the old rx_buf, Rx_full stays 1, no Ovr.
- Abort in XFER: go to IDLE, Busy<=0, no Done, rx_buf unchanged. Abort has priority over a same-cycle Sample_en.
- Lsb_first and Cpha are sampled at load and held internally for the whole transfer.

Decomposition:
- Shared package spi_pkg:
  - state enum (IDLE, XFER)
  - bit-order constants (MSB_FIRST=0, LSB_FIRST=1)
  - helper function returning the head bit of a word given bit order
- No sub-module. Counter and shifters stay inline, as each is under 20 lines.

Test Plan:
- DWIDTH=8, Cpha=0, MSB-first: write 0xA5, Data_in loopback from Data_out, 8 Sample/Shift pairs → Data_out sequence 1,0,1,0,0,1,0,1. Data_out=1 on the edge after the write. Done pulses once. Read returns 0xA5, Rx_full clears.
- Cpha=1, Lsb_first=1: write 0x3C, Data_in driven 1,1,0,0,0,0,0,0 → Data_out holds until the first Shift_en, then 0,0,1,1,1,1,0,0. rx_buf=0x03.
- Write 0x11 during XFER of 0x5A → Wcol=1, the transfer still sends 0x5A. A subsequent read clears Wcol.
- Two back-to-back transfers (0xFF then 0x00 received) without a read → Ovr=1 and read returns 0x00. Then a read in the same cycle as the next Done → old data returned, Rx_full stays 1.
- Abort after 4 samples, then reset asserted mid-second transfer → Abort: IDLE, no Done, rx_buf unchanged. Reset: all outputs 0 immediately (async, before next clk edge).
- DWIDTH=16: write 0x8001 with loopback, MSB-first → 16 pairs, Done after the 16th Sample_en, read returns 0x8001. Extra strobes in IDLE leave Data_out and rx_buf unchanged.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI shift engine.
package spi_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  localparam logic MSB_FIRST = 1'b0;
  localparam logic LSB_FIRST = 1'b1;

  // First bit to put on the wire for a word of (msb_idx+1) bits in the given order.
  function automatic logic head_bit(input logic [31:0] word,
                                    input logic [4:0]  msb_idx,
                                    input logic        order);
    return (order == MSB_FIRST) ? word[msb_idx] : word[0];
  endfunction

endpackage

// File: rtl/spi_shift_engine.sv
// SPI data-path shifter: TX/RX shift registers, bit counter, buffered receive
// register with full/overrun flags and write-collision detection. All timing
// comes from single-cycle Sample_en/Shift_en strobes on the system clock.
module spi_shift_engine
  import spi_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int CNT_W  = $clog2(DWIDTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Sample_en,
  input  logic              Shift_en,
  input  logic              Data_in,
  input  logic              Cpha,
  input  logic              Lsb_first,
  input  logic              Abort,
  input  logic              SPDR_wr_en,
  input  logic [DWIDTH-1:0] SPDR_in,
  input  logic              SPDR_rd_en,
  output logic [DWIDTH-1:0] SPDR_out,
  output logic              Data_out,
  output logic              Busy,
  output logic              Done,
  output logic              Rx_full,
  output logic              Ovr,
  output logic              Wcol
);

  localparam logic [4:0]       MSB_IDX  = 5'(DWIDTH - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWIDTH - 1);

  state_t            state_q, state_nxt;
  logic [DWIDTH-1:0] tx_reg, tx_next;
  logic [DWIDTH-1:0] rx_reg, rx_next;
  logic [DWIDTH-1:0] rx_buf;
  logic [CNT_W-1:0]  bit_cnt;
  logic              data_out_q, done_q, rx_full_q, ovr_q, wcol_q;
  logic              lsb_q, cpha_q, shifted_q;
  logic              load, do_sample, do_shift, complete;

  // Word as it looks after one more bit in each direction, in the latched order.
  assign rx_next = (lsb_q == LSB_FIRST) ? {Data_in, rx_reg[DWIDTH-1:1]}
                                        : {rx_reg[DWIDTH-2:0], Data_in};
  assign tx_next = (lsb_q == LSB_FIRST) ? {1'b0, tx_reg[DWIDTH-1:1]}
                                        : {tx_reg[DWIDTH-2:0], 1'b0};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_nxt;
  end

  // Next state and per-cycle actions; Abort overrides any strobe in XFER.
  always_comb begin
    state_nxt = state_q;
    load      = 1'b0;
    do_sample = 1'b0;
    do_shift  = 1'b0;
    complete  = 1'b0;
    case (state_q)
      IDLE: begin
        if (SPDR_wr_en) begin
          load      = 1'b1;
          state_nxt = XFER;
        end
      end
      XFER: begin
        if (Abort) begin
          state_nxt = IDLE;
        end else begin
          do_shift  = Shift_en;
          do_sample = Sample_en;
          if (Sample_en && (bit_cnt == LAST_CNT)) begin
            complete  = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Transmit side: load latches order/phase; CPHA=1 spends its first strobe driving the head bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_reg     <= '0;
      data_out_q <= 1'b0;
      lsb_q      <= MSB_FIRST;
      cpha_q     <= 1'b0;
      shifted_q  <= 1'b0;
    end else if (load) begin
      tx_reg    <= SPDR_in;
      lsb_q     <= Lsb_first;
      cpha_q    <= Cpha;
      shifted_q <= 1'b0;
      if (!Cpha) data_out_q <= head_bit(32'(SPDR_in), MSB_IDX, Lsb_first);
    end else if (do_shift) begin
      if (cpha_q && !shifted_q) begin
        data_out_q <= head_bit(32'(tx_reg), MSB_IDX, lsb_q);
        shifted_q  <= 1'b1;
      end else begin
        tx_reg     <= tx_next;
        data_out_q <= head_bit(32'(tx_next), MSB_IDX, lsb_q);
      end
    end
  end

  // Receive shifter and bit counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_reg  <= '0;
      bit_cnt <= '0;
    end else if (load) begin
      rx_reg  <= '0;
      bit_cnt <= '0;
    end else if (do_sample) begin
      rx_reg  <= rx_next;
      bit_cnt <= bit_cnt + CNT_W'(1);
    end
  end

  // Receive buffer and status flags; a read in the completion cycle suppresses overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_buf    <= '0;
      done_q    <= 1'b0;
      rx_full_q <= 1'b0;
      ovr_q     <= 1'b0;
      wcol_q    <= 1'b0;
    end else begin
      done_q <= complete;
      if (complete) rx_buf <= rx_next;

      if (complete)        rx_full_q <= 1'b1;
      else if (SPDR_rd_en) rx_full_q <= 1'b0;

      if (complete && rx_full_q && !SPDR_rd_en) ovr_q <= 1'b1;
      else if (SPDR_rd_en)                      ovr_q <= 1'b0;

      if (SPDR_wr_en && (state_q == XFER)) wcol_q <= 1'b1;
      else if (SPDR_rd_en)                 wcol_q <= 1'b0;
    end
  end

  assign SPDR_out = SPDR_rd_en ? rx_buf : '0;
  assign Data_out = data_out_q;
  assign Busy     = (state_q == XFER);
  assign Done     = done_q;
  assign Rx_full  = rx_full_q;
  assign Ovr      = ovr_q;
  assign Wcol     = wcol_q;

endmodule
